// File: rtl/fpmul_stream_pkg.sv
// Shared defaults and the result record for the FP multiply streaming block.
package fpmul_stream_pkg;

   localparam int DEF_DATA_W  = 32;
   localparam int DEF_MUL_LAT = 4;
   localparam int DEF_DEPTH   = 8;
   localparam int DEF_TAG_W   = 4;

   typedef struct packed {
      logic [DEF_DATA_W-1:0] data;
      logic [DEF_TAG_W-1:0]  tag;
   } result_t;

endpackage

// File: rtl/FPmul.sv
// Pipelined IEEE-754 single-precision multiplier, round-to-nearest-even,
// denormals flushed to zero. Result appears LAT edges after operand sample.
module FPmul #(
   parameter int LAT = 4
) (
   input  logic        clk,
   input  logic        RST_n,
   input  logic [31:0] FP_A,
   input  logic [31:0] FP_B,
   output logic [31:0] FP_Z
);

   logic [31:0]       z_c;
   logic [31:0]       pipe_q [LAT];
   logic              sign, norm, guard, sticky;
   logic [7:0]        ea, eb;
   logic [22:0]       ma, mb, frac;
   logic [47:0]       prod;
   logic [23:0]       rnd;
   logic signed [9:0] exp_r;
   logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

   // Full multiply and rounding in front of the first pipeline register.
   always_comb begin
      sign   = FP_A[31] ^ FP_B[31];
      ea     = FP_A[30:23];
      eb     = FP_B[30:23];
      ma     = FP_A[22:0];
      mb     = FP_B[22:0];
      a_nan  = (ea == 8'hFF) && (ma != '0);
      b_nan  = (eb == 8'hFF) && (mb != '0);
      a_inf  = (ea == 8'hFF) && (ma == '0);
      b_inf  = (eb == 8'hFF) && (mb == '0);
      a_zero = (ea == 8'h00);
      b_zero = (eb == 8'h00);
      prod   = {24'b0, 1'b1, ma} * {24'b0, 1'b1, mb};
      norm   = prod[47];
      frac   = '0;
      guard  = 1'b0;
      sticky = 1'b0;
      if (norm) begin
         frac   = prod[46:24];
         guard  = prod[23];
         sticky = |prod[22:0];
      end else begin
         frac   = prod[45:23];
         guard  = prod[22];
         sticky = |prod[21:0];
      end
      rnd   = {1'b0, frac} + {23'b0, guard & (sticky | frac[0])};
      exp_r = 10'(ea) + 10'(eb) - 10'd127 + 10'(norm) + 10'(rnd[23]);
      z_c   = '0;
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
         z_c = 32'h7FC0_0000;
      else if (a_inf || b_inf)
         z_c = {sign, 8'hFF, 23'b0};
      else if (a_zero || b_zero)
         z_c = {sign, 31'b0};
      else if (exp_r >= 10'sd255)
         z_c = {sign, 8'hFF, 23'b0};
      else if (exp_r <= 10'sd0)
         z_c = {sign, 31'b0};
      else
         z_c = {sign, exp_r[7:0], rnd[22:0]};
   end

   // Delay line carrying the product out to the latency boundary.
   always_ff @(posedge clk) begin
      if (!RST_n) begin
         for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= z_c;
         for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign FP_Z = pipe_q[LAT-1];

endmodule

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with full/empty flags.
module sync_fifo #(
   parameter int WIDTH = 36,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    cnt_q;
   logic             do_wr, do_rd;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem_q[rd_ptr_q];

   // Storage array; contents need no reset since empty masks them.
   always_ff @(posedge clk) begin
      if (do_wr) mem_q[wr_ptr_q] <= wr_data;
   end

   // Pointer and occupancy bookkeeping, plus overflow trap.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (wr_en) assert (!full);
         if (do_wr) wr_ptr_q <= next_ptr(wr_ptr_q);
         if (do_rd) rd_ptr_q <= next_ptr(rd_ptr_q);
         case ({do_wr, do_rd})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/fpmul_stream_ctrl.sv
// Valid/ready wrapper around FPmul: slot-marking shift register, credit
// counter covering in-flight plus buffered results, FWFT result FIFO.
module fpmul_stream_ctrl
   import fpmul_stream_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int MUL_LAT = DEF_MUL_LAT,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int TAG_W   = DEF_TAG_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          in_a,
   input  logic [DATA_W-1:0]          in_b,
   input  logic [TAG_W-1:0]           in_tag,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [TAG_W-1:0]           out_tag,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       busy
);

   localparam int CW = $clog2(DEPTH + 1);

   if (DEPTH < MUL_LAT + 1) begin : g_depth_chk
      $error("fpmul_stream_ctrl: DEPTH must be at least MUL_LAT+1");
   end
   if (MUL_LAT < 1) begin : g_lat_chk
      $error("fpmul_stream_ctrl: MUL_LAT must be at least 1");
   end
   if (DATA_W != 32) begin : g_width_chk
      $error("fpmul_stream_ctrl: FPmul is single precision, DATA_W must be 32");
   end

   logic [CW-1:0]      count_q, count_d;
   logic [MUL_LAT-1:0] vld_q, vld_d;
   logic [TAG_W-1:0]   tag_q [MUL_LAT];
   logic [DATA_W-1:0]  fp_z;
   logic               in_xfer, out_xfer, fifo_empty, fifo_full;

   // Credits are counted at accept time, so a full FIFO can never be written.
   // in_ready cannot see out_ready; draining a full block costs one bubble.
   assign in_ready  = !rst && (count_q < CW'(DEPTH));
   assign out_valid = !rst && !fifo_empty;
   assign in_xfer   = in_valid && in_ready;
   assign out_xfer  = out_valid && out_ready;
   assign count     = rst ? '0 : count_q;
   assign busy      = (count != '0);

   FPmul #(.LAT(MUL_LAT)) u_fpmul (
      .clk   (clk),
      .RST_n (!rst),
      .FP_A  (in_a),
      .FP_B  (in_b),
      .FP_Z  (fp_z)
   );

   // Next occupancy and next slot marks.
   always_comb begin
      count_d = count_q;
      case ({in_xfer, out_xfer})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      vld_d    = '0;
      vld_d[0] = in_xfer;
      for (int i = 1; i < MUL_LAT; i++) vld_d[i] = vld_q[i-1];
   end

   // Occupancy counter and slot-valid shift register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         vld_q   <= '0;
      end else begin
         count_q <= count_d;
         vld_q   <= vld_d;
      end
   end

   // Tags ride alongside the multiplier; unmarked slots are ignored.
   always_ff @(posedge clk) begin
      tag_q[0] <= in_tag;
      for (int i = 1; i < MUL_LAT; i++) tag_q[i] <= tag_q[i-1];
   end

   sync_fifo #(.WIDTH(DATA_W + TAG_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (vld_q[MUL_LAT-1]),
      .wr_data ({fp_z, tag_q[MUL_LAT-1]}),
      .rd_en   (out_xfer),
      .rd_data ({out_data, out_tag}),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   logic unused_full;
   assign unused_full = fifo_full;

endmodule

// File: tb/tb_fpmul_stream_ctrl.sv
module tb_fpmul_stream_ctrl;
   import fpmul_stream_pkg::*;

   localparam int DATA_W  = 32;
   localparam int MUL_LAT = 4;
   localparam int DEPTH   = 8;
   localparam int TAG_W   = 4;
   localparam int CW      = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              out_ready = 1'b0;
   logic [DATA_W-1:0] in_a = '0, in_b = '0;
   logic [TAG_W-1:0]  in_tag = '0;
   logic              in_ready, out_valid, busy;
   logic [DATA_W-1:0] out_data;
   logic [TAG_W-1:0]  out_tag;
   logic [CW-1:0]     count;
   logic [31:0]       cur_exp = '0;

   always #5 clk = ~clk;

   fpmul_stream_ctrl #(
      .DATA_W(DATA_W), .MUL_LAT(MUL_LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .count     (count),
      .busy      (busy)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Operand table with exactly representable products.
   logic [31:0] va [9];
   logic [31:0] vb [9];
   logic [31:0] vz [9];
   initial begin
      va[0] = 32'h3FC00000; vb[0] = 32'h40000000; vz[0] = 32'h40400000; // 1.5*2=3
      va[1] = 32'h40400000; vb[1] = 32'h40400000; vz[1] = 32'h41100000; // 3*3=9
      va[2] = 32'h3F000000; vb[2] = 32'h40800000; vz[2] = 32'h40000000; // 0.5*4=2
      va[3] = 32'hC0000000; vb[3] = 32'h3FC00000; vz[3] = 32'hC0400000; // -2*1.5=-3
      va[4] = 32'h3FA00000; vb[4] = 32'h40800000; vz[4] = 32'h40A00000; // 1.25*4=5
      va[5] = 32'hBF800000; vb[5] = 32'hBF800000; vz[5] = 32'h3F800000; // -1*-1=1
      va[6] = 32'h00000000; vb[6] = 32'h40400000; vz[6] = 32'h00000000; // 0*3=0
      va[7] = 32'h3E800000; vb[7] = 32'h3E800000; vz[7] = 32'h3D800000; // .25*.25
      va[8] = 32'h40400000; vb[8] = 32'h3FC00000; vz[8] = 32'h40900000; // 3*1.5=4.5
   end

   // Reference model: a queue of accepted results, each visible from a
   // known cycle onward, and an occupancy count of accepted-not-delivered.
   typedef struct {
      result_t r;
      int      avail;
   } pend_t;

   pend_t sb[$];
   int    cnt_m = 0;
   int    cyc   = 0;

   always @(negedge clk) begin : monitor
      bit    exp_rdy, exp_vld, acc, otr;
      pend_t p;
      cyc++;
      if (rst) begin
         chk("rst_in_ready", in_ready, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_count", count, 0);
         chk("rst_busy", busy, 0);
         sb.delete();
         cnt_m = 0;
      end else begin
         exp_rdy = (cnt_m < DEPTH);
         exp_vld = (sb.size() > 0) && (sb[0].avail <= cyc);
         chk("in_ready", in_ready, exp_rdy);
         chk("out_valid", out_valid, exp_vld);
         chk("count", count, cnt_m);
         chk("busy", busy, cnt_m != 0);
         if (exp_vld) begin
            chk("out_data", out_data, sb[0].r.data);
            chk("out_tag", out_tag, sb[0].r.tag);
         end
         acc = in_valid && exp_rdy;
         otr = exp_vld && out_ready;
         if (otr) void'(sb.pop_front());
         if (acc) begin
            p.r.data = cur_exp;
            p.r.tag  = in_tag;
            p.avail  = cyc + 1 + MUL_LAT;
            sb.push_back(p);
         end
         cnt_m = cnt_m + int'(acc) - int'(otr);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic v, input int idx, input logic [3:0] t);
      in_valid = v;
      in_a     = va[idx];
      in_b     = vb[idx];
      cur_exp  = vz[idx];
      in_tag   = t;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int lat;
      int acc;
      bit found;

      rst = 1'b1;
      out_ready = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", in_ready, 1);

      // single operation latency and value
      tick();
      put(1, 0, 4'd3);
      tick();
      in_valid = 1'b0;
      lat = 1;
      found = 0;
      while (!found && lat < 20) begin
         @(negedge clk);
         if (out_valid) found = 1;
         else lat++;
      end
      chk("single_latency", lat, MUL_LAT + 1);
      chk("single_data", out_data, 32'h40400000);
      chk("single_tag", out_tag, 4'd3);
      tick();

      // back-to-back stream with a free-running consumer
      for (int i = 0; i < 20; i++) begin
         put(1, i % 9, 4'(i));
         chk("stream_ready", in_ready, 1);
         tick();
      end
      in_valid = 1'b0;
      repeat (10) tick();

      // consumer stalled: exactly DEPTH accepted, then drained in order
      out_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 12; i++) begin
         put(1, (i + 2) % 9, 4'(i + 5));
         if (in_ready) acc++;
         tick();
      end
      in_valid = 1'b0;
      chk("bp_accepted", acc, DEPTH);
      repeat (2) tick();
      chk("bp_count", count, DEPTH);
      chk("bp_in_ready", in_ready, 0);
      out_ready = 1'b1;
      repeat (12) tick();
      chk("bp_drained", count, 0);

      // full, then consumer resumes with producer still offering
      out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         put(1, (i + 4) % 9, 4'(i + 1));
         tick();
      end
      chk("full_count", count, DEPTH);
      out_ready = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         put(1, i % 9, 4'(i + 9));
         chk("full_stream_count", count, DEPTH - 1);
         tick();
      end
      in_valid = 1'b0;
      repeat (15) tick();

      // reset with three operations in flight
      for (int i = 0; i < 3; i++) begin
         put(1, i + 1, 4'(i + 12));
         tick();
      end
      in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("post_rst_count", count, 0);
      for (int i = 0; i < 10; i++) begin
         chk("no_ghost_result", out_valid, 0);
         tick();
      end

      // result held stable while stalled
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_a      = 32'hC0000000;
      in_b      = 32'h3F000000;
      cur_exp   = 32'hBF800000;
      in_tag    = 4'd5;
      tick();
      in_valid = 1'b0;
      lat = 1;
      found = 0;
      while (!found && lat < 20) begin
         @(negedge clk);
         if (out_valid) found = 1;
         else lat++;
      end
      chk("hold_latency", lat, MUL_LAT + 1);
      for (int i = 0; i < 3; i++) begin
         chk("hold_data", out_data, 32'hBF800000);
         chk("hold_tag", out_tag, 4'd5);
         chk("hold_valid", out_valid, 1);
         @(negedge clk);
      end
      tick();
      out_ready = 1'b1;
      repeat (3) tick();
      chk("final_count", count, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
